// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage -- two-stage ID/EX pipeline slice for a 32-bit MIPS datapath.
//
// Purpose
//   Stage S1 captures and decodes the instruction word coming from IF/ID.
//   Stage S2 drives the ex_* outputs into EX. Register-file operands are read
//   while the instruction sits in S1. They are latched into ex_A/ex_B on the
//   S1->S2 edge.
//   A load-use hazard (lw in S2 whose destination is a source of S1) inserts
//   exactly one bubble into S2 and holds S1 for one cycle.
//
// Optional feature (macro IDEX_FWD_EN)
//   When IDEX_FWD_EN is defined, the ports fwd_we/fwd_rd/fwd_data are added.
//   A matching write-back then overrides the register-file data latched into
//   ex_A/ex_B. When the macro is undefined, these ports do not exist and
//   ex_A/ex_B always take rf_A/rf_B.
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   in_valid/in_instr/in_pc4   instruction from IF/ID
//   in_ready              stage accepts in_instr this cycle
//   stall                 downstream hold request (freezes S1 and S2)
//   flush                 synchronous kill of both stages (highest priority)
//   rf_rs/rf_rt           register-file read addresses
//   rf_A/rf_B             register-file read data (one cycle after address)
//   fwd_we/fwd_rd/fwd_data  write-back forwarding (IDEX_FWD_EN only)
//   ex_*                  EX-stage instruction slot
//   hazard_stall          load-use bubble inserted this cycle
// -----------------------------------------------------------------------------
module idex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic        in_ready,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rf_rs,
  output logic [4:0]  rf_rt,
  input  logic [31:0] rf_A,
  input  logic [31:0] rf_B,
`ifdef IDEX_FWD_EN
  input  logic        fwd_we,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
`endif
  output logic        ex_valid,
  output logic        ex_memread,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc4,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wreg,
  output logic [4:0]  ex_shamt,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic        hazard_stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;

  // ---------------------------------------------------------------------------
  // Instruction field split and decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;
  logic [4:0]  w_dec_wreg;
  logic [31:0] w_dec_imm;
  logic        w_dec_memread;

  assign w_op    = in_instr[31:26];
  assign w_rs    = in_instr[25:21];
  assign w_rt    = in_instr[20:16];
  assign w_rd    = in_instr[15:11];
  assign w_shamt = in_instr[10:6];
  assign w_funct = in_instr[5:0];
  assign w_imm16 = in_instr[15:0];

  always_comb begin
    w_dec_wreg    = 5'd0;
    w_dec_imm     = {{16{w_imm16[15]}}, w_imm16};
    w_dec_memread = 1'b0;
    case (w_op)
      OP_RTYPE: w_dec_wreg = w_rd;
      OP_LW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                w_dec_wreg = w_rt;
      OP_JAL:   w_dec_wreg = 5'd31;
      default:  w_dec_wreg = 5'd0;
    endcase
    case (w_op)
      OP_ANDI, OP_ORI: w_dec_imm = {16'h0000, w_imm16};
      OP_LUI:          w_dec_imm = {w_imm16, 16'h0000};
      default:         w_dec_imm = {{16{w_imm16[15]}}, w_imm16};
    endcase
    w_dec_memread = (w_op == OP_LW);
  end

  // ---------------------------------------------------------------------------
  // S1 registers (decoded instruction)
  // ---------------------------------------------------------------------------
  logic        r_s1_valid;
  logic        r_s1_memread;
  logic [5:0]  r_s1_op;
  logic [5:0]  r_s1_funct;
  logic [4:0]  r_s1_rs;
  logic [4:0]  r_s1_rt;
  logic [4:0]  r_s1_shamt;
  logic [4:0]  r_s1_wreg;
  logic [31:0] r_s1_imm;
  logic [31:0] r_s1_pc4;

  // S2 registers (EX slot)
  logic        r_ex_valid;
  logic        r_ex_memread;
  logic [31:0] r_ex_A;
  logic [31:0] r_ex_B;
  logic [31:0] r_ex_imm;
  logic [31:0] r_ex_pc4;
  logic [4:0]  r_ex_rs;
  logic [4:0]  r_ex_rt;
  logic [4:0]  r_ex_wreg;
  logic [4:0]  r_ex_shamt;
  logic [5:0]  r_ex_opcode;
  logic [5:0]  r_ex_funct;

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  logic w_hazard;
  logic w_in_ready;

  // A load in EX whose destination is a source of the instruction in S1 needs
  // one bubble. An external stall freezes everything, so no bubble is
  // inserted during a stall.
  assign w_hazard = ~stall & r_ex_valid & r_ex_memread & (r_ex_wreg != 5'd0) &
                    r_s1_valid &
                    ((r_ex_wreg == r_s1_rs) | (r_ex_wreg == r_s1_rt));

  assign w_in_ready = ~stall & ~w_hazard;

  // While S1 is held, keep re-reading its sources. The register-file data
  // then still belongs to the held instruction on the cycle it advances.
  assign rf_rs = w_in_ready ? w_rs : r_s1_rs;
  assign rf_rt = w_in_ready ? w_rt : r_s1_rt;

  // ---------------------------------------------------------------------------
  // Operand selection at the S1->S2 edge
  // ---------------------------------------------------------------------------
  logic [31:0] w_opa;
  logic [31:0] w_opb;

`ifdef IDEX_FWD_EN
  assign w_opa = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == r_s1_rs)) ? fwd_data : rf_A;
  assign w_opb = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == r_s1_rt)) ? fwd_data : rf_B;
`else
  assign w_opa = rf_A;
  assign w_opb = rf_B;
`endif

  // ---------------------------------------------------------------------------
  // S1 state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_memread <= 1'b0;
      r_s1_op      <= 6'd0;
      r_s1_funct   <= 6'd0;
      r_s1_rs      <= 5'd0;
      r_s1_rt      <= 5'd0;
      r_s1_shamt   <= 5'd0;
      r_s1_wreg    <= 5'd0;
      r_s1_imm     <= 32'd0;
      r_s1_pc4     <= 32'd0;
    end else if (flush) begin
      r_s1_valid   <= 1'b0;
    end else if (w_in_ready) begin
      // in_valid=0 loads a bubble, so a gap propagates down the pipe
      r_s1_valid   <= in_valid;
      r_s1_memread <= w_dec_memread;
      r_s1_op      <= w_op;
      r_s1_funct   <= w_funct;
      r_s1_rs      <= w_rs;
      r_s1_rt      <= w_rt;
      r_s1_shamt   <= w_shamt;
      r_s1_wreg    <= w_dec_wreg;
      r_s1_imm     <= w_dec_imm;
      r_s1_pc4     <= in_pc4;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_memread <= 1'b0;
      r_ex_A       <= 32'd0;
      r_ex_B       <= 32'd0;
      r_ex_imm     <= 32'd0;
      r_ex_pc4     <= 32'd0;
      r_ex_rs      <= 5'd0;
      r_ex_rt      <= 5'd0;
      r_ex_wreg    <= 5'd0;
      r_ex_shamt   <= 5'd0;
      r_ex_opcode  <= 6'd0;
      r_ex_funct   <= 6'd0;
    end else if (flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_memread <= 1'b0;
    end else if (stall) begin
      // hold every field
    end else if (w_hazard) begin
      // Bubble: the remaining fields are don't-care while ex_valid is 0
      r_ex_valid   <= 1'b0;
      r_ex_memread <= 1'b0;
      r_ex_wreg    <= 5'd0;
    end else begin
      r_ex_valid   <= r_s1_valid;
      r_ex_memread <= r_s1_valid & r_s1_memread;
      r_ex_A       <= w_opa;
      r_ex_B       <= w_opb;
      r_ex_imm     <= r_s1_imm;
      r_ex_pc4     <= r_s1_pc4;
      r_ex_rs      <= r_s1_rs;
      r_ex_rt      <= r_s1_rt;
      r_ex_wreg    <= r_s1_wreg;
      r_ex_shamt   <= r_s1_shamt;
      r_ex_opcode  <= r_s1_op;
      r_ex_funct   <= r_s1_funct;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready     = w_in_ready;
  assign hazard_stall = w_hazard;
  assign ex_valid     = r_ex_valid;
  assign ex_memread   = r_ex_memread;
  assign ex_A         = r_ex_A;
  assign ex_B         = r_ex_B;
  assign ex_imm       = r_ex_imm;
  assign ex_pc4       = r_ex_pc4;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_wreg      = r_ex_wreg;
  assign ex_shamt     = r_ex_shamt;
  assign ex_opcode    = r_ex_opcode;
  assign ex_funct     = r_ex_funct;

endmodule

// File: tb/tb_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_idex_stage -- directed self-checking bench for idex_stage.
// A small register-file model answers rf_rs/rf_rt one cycle later.
// Reg 9 holds 0x10. Reg 0 holds 0. Every other reg k holds 0x100+k.
// -----------------------------------------------------------------------------
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [4:0]  rf_rs;
  logic [4:0]  rf_rt;
  logic [31:0] rf_A = 32'd0;
  logic [31:0] rf_B = 32'd0;
`ifdef IDEX_FWD_EN
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif
  logic        ex_valid;
  logic        ex_memread;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc4;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_wreg;
  logic [4:0]  ex_shamt;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic        hazard_stall;

  idex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc4(in_pc4), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_A(rf_A), .rf_B(rf_B),
`ifdef IDEX_FWD_EN
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_shamt(ex_shamt),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rfval(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (a == 5'd9) return 32'h10;
    return 32'h100 + {27'd0, a};
  endfunction

  always @(posedge clk) begin
    rf_A <= rfval(rf_rs);
    rf_B <= rfval(rf_rt);
  end

  // addi $k,$0,k
  function automatic logic [31:0] mk_addi(input int k);
    return 32'h2000_0000 | (k << 16) | k;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int got;
    logic acc;
    logic [31:0] snap_imm;
    logic        snap_valid;

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc4 = 32'd0;
    stall = 1'b0; flush = 1'b0;
`ifdef IDEX_FWD_EN
    fwd_we = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
`endif
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_hazard", hazard_stall, 0);
    check("rst_ex_imm", ex_imm, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi $8,$9,-4 with reg 9 = 0x10
    in_valid = 1'b1; in_instr = 32'h2128FFFC; in_pc4 = 32'h400;
    tick();
    in_valid = 1'b0; in_instr = 32'd0;
    check("addi_lat1_valid", ex_valid, 0);
    tick();
    check("addi_valid", ex_valid, 1);
    check("addi_wreg", ex_wreg, 8);
    check("addi_imm", ex_imm, 32'hFFFFFFFC);
    check("addi_A", ex_A, 32'h10);
    check("addi_B", ex_B, 32'h108);
    check("addi_pc4", ex_pc4, 32'h400);
    tick();
    check("addi_drain", ex_valid, 0);

    // lw $8,0($9) then add $10,$8,$8
    in_valid = 1'b1; in_instr = 32'h8D280000;
    tick();
    in_instr = 32'h01085020;
    tick();
    in_valid = 1'b0; in_instr = 32'd0;
    #1;
    check("lu_lw_memread", ex_memread, 1);
    check("lu_hazard", hazard_stall, 1);
    check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_wreg", ex_wreg, 0);
    check("lu_hazard_once", hazard_stall, 0);
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rs", ex_rs, 8);
    check("lu_add_rt", ex_rt, 8);
    check("lu_add_wreg", ex_wreg, 10);
    check("lu_add_funct", ex_funct, 6'h20);
    check("lu_add_A", ex_A, 32'h108);
    tick();
    check("lu_drain", ex_valid, 0);

    // ori $3,$0,0x8001 ; lui $3,0x1234
    in_valid = 1'b1; in_instr = 32'h34038001;
    tick();
    in_instr = 32'h3C031234;
    tick();
    in_valid = 1'b0; in_instr = 32'd0;
    check("ori_imm", ex_imm, 32'h00008001);
    check("ori_wreg", ex_wreg, 3);
    tick();
    check("lui_imm", ex_imm, 32'h12340000);
    check("lui_opcode", ex_opcode, 6'h0F);
    tick();

    // stream of six addi with a 3-cycle stall in the middle
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      stall    = (cyc >= 3 && cyc <= 5);
      in_valid = (sent < 6);
      in_instr = mk_addi(sent + 1);
      #1;
      if (stall) check("stall_in_ready", in_ready, 0);
      acc        = in_valid & in_ready;
      snap_imm   = ex_imm;
      snap_valid = ex_valid;
      tick();
      if (acc) sent++;
      if (stall) begin
        check("stall_hold_valid", ex_valid, snap_valid);
        check("stall_hold_imm", ex_imm, snap_imm);
      end else if (ex_valid) begin
        got++;
        check("stream_imm", ex_imm, got);
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    check("stream_count", got, 6);

    // flush together with stall
    in_valid = 1'b1; in_instr = mk_addi(1);
    tick();
    in_instr = mk_addi(2);
    tick();
    check("fl_pre_valid", ex_valid, 1);
    stall = 1'b1; flush = 1'b1; in_valid = 1'b0;
    tick();
    check("fl_ex_valid", ex_valid, 0);
    stall = 1'b0; flush = 1'b0;
    tick();
    check("fl_s1_cleared", ex_valid, 0);

    // asynchronous reset mid-stream
    in_valid = 1'b1; in_instr = mk_addi(3);
    tick();
    tick();
    in_valid = 1'b0;
    check("ar_pre_imm", ex_imm, 3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ex_valid", ex_valid, 0);
    check("ar_ex_imm", ex_imm, 0);
    check("ar_ex_wreg", ex_wreg, 0);
    check("ar_ex_A", ex_A, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_instr = mk_addi(4);
    tick();
    in_valid = 1'b0;
    check("ar_lat1_valid", ex_valid, 0);
    tick();
    check("ar_lat2_valid", ex_valid, 1);
    check("ar_lat2_imm", ex_imm, 4);
    tick();

`ifdef IDEX_FWD_EN
    fwd_we = 1'b1; fwd_rd = 5'd9; fwd_data = 32'h0000CAFE;
    in_valid = 1'b1; in_instr = 32'h2128FFFC;
    tick();
    in_valid = 1'b0;
    tick();
    check("fwd_A", ex_A, 32'h0000CAFE);
    fwd_rd = 5'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("fwd_r0_A", ex_A, 32'h10);
    fwd_we = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
